// File: rtl/decoder2_4_strobe_seq_pkg.sv
// Shared definitions for the sequenced 2-to-4 decoder: code width, FSM
// state encodings and the code-to-one-hot decode.
package decoder_pkg;

    localparam int unsigned CODE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic logic [3:0] decode_code(input logic [CODE_W-1:0] code);
        logic [3:0] onehot;
        onehot       = '0;
        onehot[code] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/decoder2_4_strobe_seq_fifo.sv
// Small synchronous FIFO holding pending 2-bit request codes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo_code
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CODE_W-1:0] push_code,
    input  logic              pop,
    output logic [CODE_W-1:0] pop_code,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_code = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_code;
        end
    end

endmodule

// File: rtl/decoder2_4_strobe_seq.sv
// Sequenced 2-to-4 decoder: buffers 2-bit requests and replays each as a
// one-hot strobe held for HOLD_CYCLES, separated by GAP_CYCLES idle cycles.
module decoder2_4_strobe_seq
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic A1,
    input  logic A0,
    input  logic in_valid,
    output logic in_ready,
    output logic Y3,
    output logic Y2,
    output logic Y1,
    output logic Y0,
    output logic busy,
    output logic done
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        gap_q, gap_d;
    logic [3:0]        y_q, y_d;
    logic              done_q, done_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CODE_W-1:0] fifo_code;

    sync_fifo_code #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_code({A1, A0}),
        .pop      (fifo_pop),
        .pop_code (fifo_code),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

    // With en low nothing advances, so a paused strobe resumes its count.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        code_d   = fifo_code;
                        hold_d   = HOLD_LOAD;
                        state_d  = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (hold_q == 8'd0) begin
                        done_d = 1'b1;
                        if (HAS_GAP) begin
                            gap_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end else if (!fifo_empty) begin
                            // Zero gap: chain straight into the next strobe.
                            fifo_pop = 1'b1;
                            code_d   = fifo_code;
                            hold_d   = HOLD_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 8'd0) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            code_d   = fifo_code;
                            hold_d   = HOLD_LOAD;
                            state_d  = ST_DRIVE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        y_d = (en && (state_d == ST_DRIVE)) ? decode_code(code_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign Y3   = y_q[3];
    assign Y2   = y_q[2];
    assign Y1   = y_q[1];
    assign Y0   = y_q[0];
    assign done = done_q;

endmodule

// File: tb/tb_decoder2_4_strobe_seq.sv
// Self-checking bench for decoder2_4_strobe_seq: directed scenarios plus
// randomized traffic checked by a done-driven scoreboard monitor.
module tb_decoder2_4_strobe_seq;

    localparam int unsigned HOLD   = 4;
    localparam int unsigned GAP    = 1;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PERIOD = HOLD + GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, a1 = 1'b0, a0 = 1'b0, in_valid = 1'b0;
    logic in_ready, y3, y2, y1, y0, busy, done;
    logic en0 = 1'b0, a1_0 = 1'b0, a0_0 = 1'b0, valid0 = 1'b0;
    logic ready0, y3_0, y2_0, y1_0, y0_0, busy0, done0;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_q[$];
    int unsigned hi_cnt[4];
    int unsigned done_total = 0;
    logic        en_at_edge  = 1'b0;
    logic        rst_at_edge = 1'b1;

    decoder2_4_strobe_seq #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .A1(a1), .A0(a0), .in_valid(in_valid),
        .in_ready(in_ready), .Y3(y3), .Y2(y2), .Y1(y1), .Y0(y0),
        .busy(busy), .done(done)
    );

    decoder2_4_strobe_seq #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .FIFO_DEPTH(DEPTH)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en0), .A1(a1_0), .A0(a0_0), .in_valid(valid0),
        .in_ready(ready0), .Y3(y3_0), .Y2(y2_0), .Y1(y1_0), .Y0(y0_0),
        .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        en_at_edge  <= en;
        rst_at_edge <= rst;
    end

    function automatic logic [3:0] yv();
        return {y3, y2, y1, y0};
    endfunction

    function automatic logic [3:0] onehot(input int unsigned code);
        return 4'(1 << code);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a request; if the DUT is ready it is taken on the coming edge.
    task automatic offer(input logic [1:0] code);
        a1       = code[1];
        a0       = code[0];
        in_valid = 1'b1;
        #1;
        if (in_ready) exp_q.push_back(code);
    endtask

    // Scoreboard monitor: each done closes one strobe and is matched against
    // the oldest accepted request; it must have lit only its own line HOLD times.
    always @(negedge clk) begin
        logic [3:0]  yvec;
        logic [1:0]  e;
        int unsigned sum;
        yvec = yv();
        if (rst_at_edge) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        end else begin
            if (done) begin
                done_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done=1 expected no outstanding strobe");
                end else begin
                    e   = exp_q.pop_front();
                    sum = hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3];
                    if (hi_cnt[e] != HOLD || sum != HOLD) begin
                        errors++;
                        $display("FAIL strobe_len: line Y%0d got %0d of %0d high cycles expected %0d of %0d",
                                 e, hi_cnt[e], sum, HOLD, HOLD);
                    end
                end
                for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
            end
            checks++;
            if ($countones(yvec) > 1 || (!en_at_edge && yvec != 4'b0000)) begin
                errors++;
                $display("FAIL y_rule: got Y=%b en_prev=%b expected one-hot and zero when paused",
                         yvec, en_at_edge);
            end
            for (int i = 0; i < 4; i++) if (yvec[i]) hi_cnt[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected self-termination");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned dones_seen;
        int unsigned base;
        int          viol;
        int          n;
        int          t;
        logic [3:0]  ey;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_y", int'(yv()), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy_g0", int'(busy0), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Single request: code 10 lights Y2 for HOLD cycles after one idle cycle
        @(negedge clk);
        offer(2'b10);
        chk("single_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("single_latency_y", int'(yv()), 0);
        chk("single_busy", int'(busy), 1);
        for (int i = 0; i < int'(HOLD); i++) begin
            @(negedge clk);
            chk("single_y2", int'(yv()), int'(4'b0100));
            chk("single_done_low", int'(done), 0);
        end
        @(negedge clk);
        chk("single_y_fall", int'(yv()), 0);
        chk("single_done", int'(done), 1);
        @(negedge clk);
        chk("single_busy_fall", int'(busy), 0);
        chk("single_done_pulse", int'(done), 0);

        // Backlog: four codes on consecutive edges, checked cycle by cycle
        @(negedge clk);
        dones_seen = 0;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            t  = k - 2;
            ey = 4'b0000;
            if (t >= 0 && t < int'(4 * PERIOD) && (t % int'(PERIOD)) < int'(HOLD))
                ey = onehot(t / int'(PERIOD));
            chk("backlog_y", int'(yv()), int'(ey));
            chk("backlog_done", int'(done),
                int'(t >= int'(HOLD) && t < int'(4 * PERIOD) && ((t - int'(HOLD)) % int'(PERIOD)) == 0));
            if (done) dones_seen++;
            if (k < 4) begin
                offer(2'(k));
                chk("backlog_ready", int'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("backlog_done_count", int'(dones_seen), 4);

        // Full FIFO while paused: fifth request must be refused
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            offer(2'(3 - (k % 4)));
            chk("full_ready", int'(in_ready), int'(k < 4));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_hold_ready", int'(in_ready), 0);
        chk("full_paused_y", int'(yv()), 0);
        base = done_total;
        en   = 1'b1;
        n    = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("full_drain_in_time", int'(n < 60), 1);
        chk("full_strobe_count", int'(done_total - base), 4);

        // Pause during the second high cycle of a Y1 strobe
        @(negedge clk);
        offer(2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pause_hi1", int'(yv()), int'(4'b0010));
        @(negedge clk);
        chk("pause_hi2", int'(yv()), int'(4'b0010));
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pause_low", int'(yv()), 0);
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pause_resume", int'(yv()), int'(4'b0010));
        end
        @(negedge clk);
        chk("pause_end_y", int'(yv()), 0);
        chk("pause_end_done", int'(done), 1);
        @(negedge clk);

        // Reset during a Y3 strobe with two requests queued
        @(negedge clk);
        offer(2'b11);
        @(negedge clk);
        offer(2'b10);
        @(negedge clk);
        offer(2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstmid_y3", int'(yv()), int'(4'b1000));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_y", int'(yv()), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_ready", int'(in_ready), 1);
        chk("rstmid_done", int'(done), 0);
        viol = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (yv() != 4'b0000 || done || busy) viol++;
        end
        chk("rstmid_quiet", viol, 0);

        // Randomized traffic with random pauses and bogus data on idle cycles
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 1) == 1) begin
                offer(2'($urandom_range(0, 3)));
            end else begin
                in_valid = 1'b0;
                a1 = 1'($urandom_range(0, 1));
                a0 = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        en       = 1'b1;
        n        = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("random_drain_in_time", int'(n < 300), 1);
        chk("random_queue_empty", exp_q.size(), 0);

        // Zero-gap build: two 01 codes give one continuous 8-cycle Y1 run
        @(negedge clk);
        en0 = 1'b1;
        a1_0 = 1'b0;
        a0_0 = 1'b1;
        valid0 = 1'b1;
        #1;
        chk("g0_ready1", int'(ready0), 1);
        @(negedge clk);
        chk("g0_ready2", int'(ready0), 1);
        @(negedge clk);
        valid0 = 1'b0;
        for (int rel = 1; rel <= 10; rel++) begin
            if (rel > 1) @(negedge clk);
            chk("g0_y", int'({y3_0, y2_0, y1_0, y0_0}), (rel <= 8) ? int'(4'b0010) : 0);
            chk("g0_done", int'(done0), int'(rel == 5 || rel == 9));
        end
        chk("g0_idle", int'(busy0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
